alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  Registered N-bit integer ALU for the CPU datapath execute stage.
//  Takes operands A and B and a 3-bit opcode OP. Produces result C and a signed-overflow flag OV.
//  Outputs are registered, with one cycle of latency, on a single clock.
// PARAMETERS
//  N   32   operand/result width in bits; N >= 2, power of two (shift amount = B[$clog2(N)-1:0])
// PORTS
//  clk  in   1    system clock; all state updates on rising edge
//  rst  in   1    synchronous, active-high reset
//  A    in   N    operand A (two's complement for ADD/SUB flagging)
//  B    in   N    operand B; low $clog2(N) bits = shift amount for shift ops
//  OP   in   3    operation select (table below)
//  C    out  N    registered result
//  OV   out  1    registered signed-overflow flag
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - On a rising clk with rst=1: C <= 0, OV <= 0. Reset takes priority over any OP.
//  - On a rising clk with rst=0: C and OV are loaded from the combinational result of the current A, B and OP.
//  - Latency is exactly 1 cycle; no enable or handshake. A new op is accepted every cycle.
//  - Opcodes:
//      000 ADD  C = A + B (mod 2^N)
//      001 SUB  C = A - B (mod 2^N)
//      010 AND  C = A & B
//      011 OR   C = A | B
//      100 XOR  C = A ^ B
//      101 SLL  C = A << B[$clog2(N)-1:0]
//      110 SRL  C = A >> B[$clog2(N)-1:0]   (zero fill)
//      111 SRA  C = $signed(A) >>> B[$clog2(N)-1:0]  (sign fill)
//  - OV, ADD: 1 iff A[N-1]==B[N-1] and C[N-1]!=A[N-1].
//  - OV, SUB: 1 iff A[N-1]!=B[N-1] and C[N-1]!=A[N-1].
//  - OV, all other ops: 0.
//  - Unsigned carry/borrow is not reported. Wrap-around is silent apart from OV.
//  - Shift amount 0 passes A through unchanged.
//  - Upper bits of B above the shift field are ignored for shifts.
//  - Reset asserted mid-stream: the next edge clears C and OV. The result of the in-flight op is discarded.
//  - After rst deasserts, the first edge loads a valid result.
//  - Outputs never depend combinationally on inputs; no X may propagate from reset state.
// TESTING (N=32; check C/OV one edge after applying inputs)
//  1. Reset: rst=1 for 2 edges with A=345, B=234, OP=000
//     -> C=0, OV=0. Release rst -> next edge C=579, OV=0.
//  2. ADD/SUB:
//     - 213+345 -> C=558, OV=0.
//     - 672-85 -> C=587, OV=0.
//     - 341-943 -> C=32'hFFFFFDA6, OV=0.
//  3. Overflow:
//     - ADD 32'h7FFFFFFF+1 -> C=32'h80000000, OV=1.
//     - SUB 32'h80000000-1 -> C=32'h7FFFFFFF, OV=1.
//     - ADD 32'hFFFFFFFF+1 -> C=0, OV=0.
//  4. Logic:
//     - AND 437&768 -> C=256.
//     - OR 962|123 -> C=1019.
//     - XOR 67^24 -> C=91.
//     - OV=0 for all three.
//  5. Shifts:
//     - SLL 1<<31 -> 32'h80000000.
//     - SRL 32'h80000000>>4 -> 32'h08000000.
//     - SRA 32'h80000000>>>4 -> 32'hF8000000.
//     - SLL by B=32 (field=0) -> C=A.
//  6. Back-to-back ops every cycle, then rst=1 mid-stream
//     -> each C matches the previous cycle's inputs; the cycle after rst shows C=0, OV=0.

Source files
------------

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode/result bundle between datapath and ALU
interface alu_if #(
   parameter int N = 32
);
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [2:0]   OP;
   logic [N-1:0] C;
   logic         OV;

   // The datapath drives operands and opcode and consumes the registered result
   modport master (
      output A,
      output B,
      output OP,
      input  C,
      input  OV
   );

   // The ALU consumes operands and opcode and drives the registered result
   modport slave (
      input  A,
      input  B,
      input  OP,
      output C,
      output OV
   );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - registered N-bit integer ALU with signed-overflow flag
module alu #(
   parameter int N = 32
) (
   input  logic  clk,
   input  logic  rst,
   alu_if.slave  bus
);
   localparam int SW = $clog2(N);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   logic [N-1:0]  c_d, c_q;
   logic          ov_d, ov_q;
   logic [SW-1:0] shamt;
   logic [N-1:0]  sum, diff;

   // Only the low bits of B form the shift amount; the rest is ignored for shifts
   assign shamt = bus.B[SW-1:0];
   assign sum   = bus.A + bus.B;
   assign diff  = bus.A - bus.B;

   // Combinational result and overflow flag for the operation presented this cycle
   always_comb begin
      c_d  = '0;
      ov_d = 1'b0;
      case (bus.OP)
         OP_ADD: begin
            c_d  = sum;
            ov_d = (bus.A[N-1] == bus.B[N-1]) && (sum[N-1] != bus.A[N-1]);
         end
         OP_SUB: begin
            c_d  = diff;
            ov_d = (bus.A[N-1] != bus.B[N-1]) && (diff[N-1] != bus.A[N-1]);
         end
         OP_AND: c_d = bus.A & bus.B;
         OP_OR:  c_d = bus.A | bus.B;
         OP_XOR: c_d = bus.A ^ bus.B;
         OP_SLL: c_d = bus.A << shamt;
         OP_SRL: c_d = bus.A >> shamt;
         OP_SRA: c_d = $signed(bus.A) >>> shamt;
         default: begin
            c_d  = '0;
            ov_d = 1'b0;
         end
      endcase
   end

   // Output register; reset wins over any operation and discards the in-flight result
   always_ff @(posedge clk) begin
      if (rst) begin
         c_q  <= '0;
         ov_q <= 1'b0;
      end else begin
         c_q  <= c_d;
         ov_q <= ov_d;
      end
   end

   assign bus.C  = c_q;
   assign bus.OV = ov_q;
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu with behavioural reference model
module tb_alu;
   logic clk;
   logic rst;

   alu_if #(.N(32)) bus ();

   alu #(.N(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;

   logic [31:0] exp_c;
   logic        exp_ov;
   logic        exp_valid = 1'b0;

   logic [31:0] lit_c;
   logic        lit_ov;
   logic        lit_valid = 1'b0;
   string       lit_name = "";

   // Reference: exact integer arithmetic in 64 bits, then wrap to 32
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op,
                                 output logic [31:0] c, output logic ov);
      longint          sa, sb, r, lim;
      longint unsigned ua, p;
      int              s;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      s   = int'(b % 32);
      p   = 64'd1 << s;
      lim = 64'sd2147483648;
      ov  = 1'b0;
      c   = '0;
      case (op)
         3'd0: begin r = sa + sb; c = r[31:0]; ov = (r >= lim) || (r < -lim); end
         3'd1: begin r = sa - sb; c = r[31:0]; ov = (r >= lim) || (r < -lim); end
         3'd2: c = a & b;
         3'd3: c = a | b;
         3'd4: c = a ^ b;
         3'd5: begin ua = ua * p; c = ua[31:0]; end
         3'd6: begin ua = ua / p; c = ua[31:0]; end
         default: begin
            if (sa >= 0) r = sa / longint'(p);
            else         r = (sa - (longint'(p) - 1)) / longint'(p);
            c = r[31:0];
         end
      endcase
   endfunction

   // Model: what the outputs must hold after each rising edge
   always @(posedge clk) begin
      if (rst) begin
         exp_c  = '0;
         exp_ov = 1'b0;
      end else begin
         model(bus.A, bus.B, bus.OP, exp_c, exp_ov);
      end
      exp_valid = 1'b1;
   end

   // Compare process: model check every cycle, plus literal checks when requested
   always @(negedge clk) begin
      if (exp_valid) begin
         checks++;
         if (bus.C !== exp_c || bus.OV !== exp_ov) begin
            errors++;
            $display("FAIL model t=%0t: C=%h OV=%b expected C=%h OV=%b",
                     $time, bus.C, bus.OV, exp_c, exp_ov);
         end
      end
      if (lit_valid) begin
         checks++;
         if (bus.C !== lit_c || bus.OV !== lit_ov) begin
            errors++;
            $display("FAIL %s: C=%h OV=%b expected C=%h OV=%b",
                     lit_name, bus.C, bus.OV, lit_c, lit_ov);
         end
      end
   end

   // Call right after a rising edge: arms a literal check for the next falling edge
   task automatic check_lit(input logic [31:0] c, input logic ov, input string name);
      #1;
      lit_c     = c;
      lit_ov    = ov;
      lit_name  = name;
      lit_valid = 1'b1;
      @(negedge clk);
      #1;
      lit_valid = 1'b0;
   endtask

   task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [31:0] c, input logic ov, input string name);
      bus.A  = a;
      bus.B  = b;
      bus.OP = op;
      @(posedge clk);
      check_lit(c, ov, name);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0000_0000;
         4: return 32'(2 ** $urandom_range(0, 31));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst    = 1'b1;
      bus.A  = 32'd345;
      bus.B  = 32'd234;
      bus.OP = 3'b000;

      @(posedge clk);
      check_lit(32'd0, 1'b0, "reset_edge1");
      check_lit(32'd0, 1'b0, "reset_edge2");
      rst = 1'b0;
      @(posedge clk);
      check_lit(32'd579, 1'b0, "reset_release");

      directed(32'd213, 32'd345, 3'd0, 32'd558, 1'b0, "add");
      directed(32'd672, 32'd85, 3'd1, 32'd587, 1'b0, "sub");
      directed(32'd341, 32'd943, 3'd1, 32'hFFFF_FDA6, 1'b0, "sub_neg");
      directed(32'h7FFF_FFFF, 32'd1, 3'd0, 32'h8000_0000, 1'b1, "add_ov");
      directed(32'h8000_0000, 32'd1, 3'd1, 32'h7FFF_FFFF, 1'b1, "sub_ov");
      directed(32'hFFFF_FFFF, 32'd1, 3'd0, 32'h0000_0000, 1'b0, "add_wrap");
      directed(32'd437, 32'd768, 3'd2, 32'd256, 1'b0, "and");
      directed(32'd962, 32'd123, 3'd3, 32'd1019, 1'b0, "or");
      directed(32'd67, 32'd24, 3'd4, 32'd91, 1'b0, "xor");
      directed(32'd1, 32'd31, 3'd5, 32'h8000_0000, 1'b0, "sll");
      directed(32'h8000_0000, 32'd4, 3'd6, 32'h0800_0000, 1'b0, "srl");
      directed(32'h8000_0000, 32'd4, 3'd7, 32'hF800_0000, 1'b0, "sra");
      directed(32'h1234_5678, 32'd32, 3'd5, 32'h1234_5678, 1'b0, "sll_field0");
      directed(32'h8000_0001, 32'hFFFF_FFE1, 3'd7, 32'hC000_0000, 1'b0, "sra_upper_b");

      // Back-to-back ops then reset mid-stream
      directed(32'd10, 32'd20, 3'd0, 32'd30, 1'b0, "b2b_0");
      directed(32'd10, 32'd20, 3'd1, 32'hFFFF_FFF6, 1'b0, "b2b_1");
      bus.A  = 32'h7FFF_FFFF;
      bus.B  = 32'd1;
      bus.OP = 3'd0;
      rst    = 1'b1;
      @(posedge clk);
      check_lit(32'd0, 1'b0, "rst_mid");
      rst = 1'b0;
      @(posedge clk);
      check_lit(32'h8000_0000, 1'b1, "after_rst_mid");

      // Randomized stream with occasional reset, checked by the model every cycle
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #1;
         rst    = ($urandom_range(0, 39) == 0);
         bus.A  = pick();
         bus.B  = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 2**27 - 1), 5'(i)} : pick();
         bus.OP = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
